// File: rtl/alu_divider.sv
// Sequential unsigned restoring divider for the ALU datapath.
// One quotient bit is produced per CALC cycle by shifting {remainder, quotient}
// left and trial-subtracting the divisor. Operands are taken with start when
// the unit is idle or finishing; results are held until the next completion.
module alu_divider #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] dividend,
  input  logic [DATA_SIZE-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] quotient,
  output logic [DATA_SIZE-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] q_reg;
  logic [DATA_SIZE-1:0] dvs_reg;
  logic [DATA_SIZE:0]   rem_reg;
  logic [CNT_W-1:0]     cnt;
  // Set on a zero-divisor accept; the result is published on the following
  // edge so that done arrives one edge after the start sample.
  logic                 dz_pend;

  logic [DATA_SIZE+1:0] shifted;
  logic [DATA_SIZE+1:0] diff;
  logic                 q_bit;
  logic [DATA_SIZE:0]   rem_next;
  logic [DATA_SIZE-1:0] q_next;

  // Trial subtraction of the zero-extended divisor; one extra bit on top so
  // the sign of the difference is directly visible.
  function automatic logic [DATA_SIZE+1:0] trial_sub(
    input logic [DATA_SIZE+1:0] val,
    input logic [DATA_SIZE-1:0] dvs
  );
    return val - {2'b00, dvs};
  endfunction

  // Restore step: keep the difference if non-negative, else the shifted value.
  function automatic logic [DATA_SIZE:0] restore(
    input logic [DATA_SIZE+1:0] val,
    input logic [DATA_SIZE+1:0] dif
  );
    return dif[DATA_SIZE+1] ? val[DATA_SIZE:0] : dif[DATA_SIZE:0];
  endfunction

  // One restoring iteration computed from the current partial remainder.
  always_comb begin
    shifted  = {rem_reg, q_reg[DATA_SIZE-1]};
    diff     = trial_sub(shifted, dvs_reg);
    q_bit    = ~diff[DATA_SIZE+1];
    rem_next = restore(shifted, diff);
    q_next   = {q_reg[DATA_SIZE-2:0], q_bit};
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            quotient  <= q_next;
            remainder <= rem_next[DATA_SIZE-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        IDLE, DONE: begin
          if (state == DONE && dz_pend) begin
            // Publish the zero-divisor result; q_reg still holds the dividend.
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            dz_pend     <= 1'b0;
          end else if (start) begin
            div_by_zero <= 1'b0;
            q_reg       <= dividend;
            if (divisor != '0) begin
              dvs_reg <= divisor;
              rem_reg <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= CALC;
            end else begin
              dz_pend <= 1'b1;
              state   <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider (DATA_SIZE = 16). Expected results are
// pushed to a scoreboard queue when an operation is driven and popped when
// the divider signals done.
module tb_alu_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  alu_divider #(.DATA_SIZE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the expected result, drive start for one cycle, wait for done.
  // Called at a negedge; returns at the negedge where done is high.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output int lat, output int bcnt,
                       output bit tmo);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.q  = (b != 0) ? a / b : 16'hFFFF;
    e.r  = (b != 0) ? a % b : a;
    e.dz = (b == 0);
    sb.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      @(posedge clk); @(negedge clk);
      lat++;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = 16'hAAAA; divisor = 16'h5555;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] q, r; logic dz; int lat, bcnt; bit tmo; exp_t e;
    do_op(16'd100, 16'd7, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== e.q || r !== e.r || dz !== e.dz) begin
      n_fail++;
      $display("FAIL basic_100_7: q=%0d r=%0d dz=%b tmo=%b, required q=%0d r=%0d dz=%b",
               q, r, dz, tmo, e.q, e.r, e.dz);
    end
    n_tests++;
    if (lat != 16 || bcnt != 16) begin
      n_fail++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, required 16/16", lat, bcnt);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || q !== quotient) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b q=%0d, required done=0 q held %0d", done, quotient, q);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r; logic dz; int lat, bcnt; bit tmo; exp_t e;
    do_op(16'h1234, 16'h0000, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== e.q || r !== e.r || dz !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_result: q=%h r=%h dz=%b, required q=%h r=%h dz=1", q, r, dz, e.q, e.r);
    end
    n_tests++;
    if (lat != 1 || bcnt != 0) begin
      n_fail++;
      $display("FAIL div_zero_timing: latency=%0d busy_cycles=%0d, required 1/0", lat, bcnt);
    end
    @(negedge clk);
    do_op(16'd10, 16'd3, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== e.q || r !== e.r || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL after_div_zero: q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=0", q, r, dz, e.q, e.r);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] ta[4] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd0};
    logic [15:0] tb[4] = '{16'd1,    16'd9, 16'hFFFF, 16'd3};
    logic [15:0] tq[4] = '{16'hFFFF, 16'd0, 16'd1,    16'd0};
    logic [15:0] tr[4] = '{16'd0,    16'd5, 16'd0,    16'd0};
    logic [15:0] q, r; logic dz; int lat, bcnt; bit tmo; exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(ta[i], tb[i], q, r, dz, lat, bcnt, tmo);
      e = sb.pop_front();
      n_tests++;
      if (tmo || q !== tq[i] || r !== tr[i] || dz !== 1'b0 || lat != 16 || q !== e.q || r !== e.r) begin
        n_fail++;
        $display("FAIL boundary_%0d (%h/%h): q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=0 lat=16",
                 i, ta[i], tb[i], q, r, dz, lat, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_start_abuse();
    exp_t e; int lat, ndone; bit tmo;
    @(negedge clk);
    e.a = 16'd1000; e.b = 16'd10; e.q = 16'd100; e.r = 16'd0; e.dz = 1'b0;
    sb.push_back(e);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    @(posedge clk); @(negedge clk);
    lat = 0; tmo = 1'b1; ndone = 0;
    for (int i = 0; i < 40; i++) begin
      dividend = 16'($urandom); divisor = 16'($urandom_range(0, 20));
      @(posedge clk); @(negedge clk);
      lat++;
      if (done) begin
        tmo = 1'b0; ndone++;
        break;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (tmo || quotient !== e.q || remainder !== e.r || lat != 16) begin
      n_fail++;
      $display("FAIL start_held_result: q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=16",
               quotient, remainder, lat, e.q, e.r);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_tests++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL start_held_done_count: %0d done pulses, required 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q, r; logic dz; int lat, bcnt; bit tmo; exp_t e;
    @(negedge clk);
    do_op(16'd20, 16'd6, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== e.q || r !== e.r) begin
      n_fail++;
      $display("FAIL b2b_first: q=%0d r=%0d, required q=%0d r=%0d", q, r, e.q, e.r);
    end
    // Still in the done cycle: this start is sampled while DONE.
    do_op(16'd50, 16'd7, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== 16'd7 || r !== 16'd1 || lat != 16 || q !== e.q || r !== e.r) begin
      n_fail++;
      $display("FAIL b2b_second: q=%0d r=%0d lat=%0d, required q=7 r=1 lat=16", q, r, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] q, r; logic dz; int lat, bcnt, ndone; bit tmo; exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = 16'd999; divisor = 16'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b dz=%b q=%h r=%h, required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles with done/busy after reset, required 0", ndone);
    end
    do_op(16'd999, 16'd4, q, r, dz, lat, bcnt, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || q !== 16'd249 || r !== 16'd3 || q !== e.q || r !== e.r) begin
      n_fail++;
      $display("FAIL after_reset_999_4: q=%0d r=%0d, required q=249 r=3", q, r);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r; logic dz; int lat, bcnt; bit tmo; exp_t e;
    logic [31:0] recon;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      @(negedge clk);
      do_op(a, b, q, r, dz, lat, bcnt, tmo);
      e = sb.pop_front();
      recon = 32'(q) * 32'(b) + 32'(r);
      n_tests++;
      if (tmo || recon !== 32'(a) || r >= b || lat != 16 || dz !== 1'b0 ||
          q !== e.q || r !== e.r) begin
        n_fail++;
        $display("FAIL random_%0d (%0d/%0d): q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=16",
                 i, a, b, q, r, lat, e.q, e.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_start_abuse();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
